// File: rtl/tero_puf_pkg.sv
// Shared types and constants for the TERO PUF scan controller.
// Holds the FSM state encoding, the measurement phase type and the settle length.
package tero_puf_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        RUN,
        SETTLE,
        CAPTURE,
        DONE
    } state_t;

    // Phase A measures the even TERO of a pair, phase B the odd one.
    typedef enum logic {
        PHASE_A = 1'b0,
        PHASE_B = 1'b1
    } phase_t;

    // Covers the external counter's synchroniser latency after excitation stops.
    localparam int SETTLE_CYCLES = 2;

endpackage

// File: rtl/tero_scan_ctrl_if.sv
// Host/TERO-array bundle for the scan controller.
// The master side requests scans and supplies counts; the slave side is the controller.
interface tero_scan_ctrl_if #(
    parameter int N_TERO_BITS = 5,
    parameter int N_BITS      = 16,
    parameter int CNT_BITS    = 16
) ();

    logic                         start;
    logic [N_TERO_BITS-1:0]       base_idx;
    logic [CNT_BITS-1:0]          cnt_val;
    logic [N_TERO_BITS-1:0]       tero_sel;
    logic                         tero_en;
    logic                         cnt_clr;
    logic                         busy;
    logic                         done;
    logic [N_BITS-1:0]            response;
    logic [$clog2(N_BITS+1)-1:0]  tie_cnt;

    modport master (
        output start, base_idx, cnt_val,
        input  tero_sel, tero_en, cnt_clr, busy, done, response, tie_cnt
    );

    modport slave (
        input  start, base_idx, cnt_val,
        output tero_sel, tero_en, cnt_clr, busy, done, response, tie_cnt
    );

endinterface

// File: rtl/tero_window_timer.sv
// Loadable down-counter timing the RUN window and the SETTLE gap.
// expire is high while the count sits at zero, i.e. in the last cycle of a loaded interval.
module tero_window_timer #(
    parameter int WIDTH = 11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             expire
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire = (count_q == '0);

endmodule

// File: rtl/tero_scan_ctrl.sv
// TERO PUF scan controller: measures TERO pairs in turn and derives one response bit per pair.
// All outputs are registered from the next-state decode so they change cleanly at the edge.
module tero_scan_ctrl #(
    parameter int N_TERO_BITS   = 5,
    parameter int N_BITS        = 16,
    parameter int WINDOW_CYCLES = 1024,
    parameter int CNT_BITS      = 16
) (
    input  logic            clk,
    input  logic            reset,
    tero_scan_ctrl_if.slave bus
);

    import tero_puf_pkg::*;

    localparam int K_BITS   = (N_BITS > 1) ? $clog2(N_BITS) : 1;
    localparam int TIE_BITS = $clog2(N_BITS + 1);
    localparam int TMR_MAX  = (WINDOW_CYCLES > SETTLE_CYCLES) ? WINDOW_CYCLES : SETTLE_CYCLES;
    localparam int TMR_BITS = $clog2(TMR_MAX + 1);

    state_t                 state_q, state_d;
    phase_t                 phase_q, phase_d;
    logic [K_BITS-1:0]      k_q, k_d;
    logic [N_TERO_BITS-1:0] base_q, base_d;
    logic [N_TERO_BITS-1:0] sel_q, sel_d;
    logic [CNT_BITS-1:0]    count_a_q, count_a_d;
    logic [N_BITS-1:0]      resp_q, resp_d;
    logic [TIE_BITS-1:0]    tie_q, tie_d;
    logic                   en_q, en_d;
    logic                   clr_q, clr_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic                   tmr_load;
    logic [TMR_BITS-1:0]    tmr_val;
    logic                   tmr_expire;

    // Index arithmetic wraps modulo 2^N_TERO_BITS by truncation.
    function automatic logic [N_TERO_BITS-1:0] sel_of(
        input logic [N_TERO_BITS-1:0] base,
        input logic [K_BITS-1:0]      k,
        input phase_t                 phase
    );
        return base + N_TERO_BITS'({k, phase == PHASE_B});
    endfunction

    tero_window_timer #(
        .WIDTH(TMR_BITS)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .load    (tmr_load),
        .load_val(tmr_val),
        .expire  (tmr_expire)
    );

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        k_d       = k_q;
        base_d    = base_q;
        sel_d     = sel_q;
        count_a_d = count_a_q;
        resp_d    = resp_q;
        tie_d     = tie_q;
        tmr_load  = 1'b0;
        tmr_val   = '0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    base_d  = bus.base_idx;
                    k_d     = '0;
                    phase_d = PHASE_A;
                    resp_d  = '0;
                    tie_d   = '0;
                    sel_d   = bus.base_idx;
                    state_d = CLR;
                end
            end
            CLR: begin
                tmr_load = 1'b1;
                tmr_val  = TMR_BITS'(WINDOW_CYCLES - 1);
                state_d  = RUN;
            end
            RUN: begin
                if (tmr_expire) begin
                    tmr_load = 1'b1;
                    tmr_val  = TMR_BITS'(SETTLE_CYCLES - 1);
                    state_d  = SETTLE;
                end
            end
            SETTLE: begin
                if (tmr_expire) begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                if (phase_q == PHASE_A) begin
                    count_a_d = bus.cnt_val;
                    phase_d   = PHASE_B;
                    sel_d     = sel_of(base_q, k_q, PHASE_B);
                    state_d   = CLR;
                end else begin
                    // A tie leaves the bit at 0 and is reported separately.
                    resp_d[k_q] = (count_a_q > bus.cnt_val);
                    if (count_a_q == bus.cnt_val) begin
                        tie_d = tie_q + TIE_BITS'(1);
                    end
                    if (k_q < K_BITS'(N_BITS - 1)) begin
                        k_d     = k_q + K_BITS'(1);
                        phase_d = PHASE_A;
                        sel_d   = sel_of(base_q, k_q + K_BITS'(1), PHASE_A);
                        state_d = CLR;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        en_d   = (state_d == RUN);
        clr_d  = (state_d == CLR);
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            phase_q   <= PHASE_A;
            k_q       <= '0;
            base_q    <= '0;
            sel_q     <= '0;
            count_a_q <= '0;
            resp_q    <= '0;
            tie_q     <= '0;
            en_q      <= 1'b0;
            clr_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            k_q       <= k_d;
            base_q    <= base_d;
            sel_q     <= sel_d;
            count_a_q <= count_a_d;
            resp_q    <= resp_d;
            tie_q     <= tie_d;
            en_q      <= en_d;
            clr_q     <= clr_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.tero_sel = sel_q;
    assign bus.tero_en  = en_q;
    assign bus.cnt_clr  = clr_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.response = resp_q;
    assign bus.tie_cnt  = tie_q;

endmodule

// File: tb/tb_tero_scan_ctrl.sv
// Directed bench for tero_scan_ctrl: two instances (4-cycle and 1-cycle windows, 2 pairs each)
// driven from a shared count table indexed by the selected TERO.
module tb_tero_scan_ctrl;

    logic        clk = 1'b0;
    logic        reset_r;
    logic        start_r;
    logic        use_b;
    logic [4:0]  base_r;
    logic [15:0] cnt_tab [32];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    tero_scan_ctrl_if #(.N_TERO_BITS(5), .N_BITS(2), .CNT_BITS(16)) bus_a ();
    tero_scan_ctrl_if #(.N_TERO_BITS(5), .N_BITS(2), .CNT_BITS(16)) bus_b ();

    assign bus_a.start    = start_r & ~use_b;
    assign bus_b.start    = start_r & use_b;
    assign bus_a.base_idx = base_r;
    assign bus_b.base_idx = base_r;
    assign bus_a.cnt_val  = cnt_tab[bus_a.tero_sel];
    assign bus_b.cnt_val  = cnt_tab[bus_b.tero_sel];

    tero_scan_ctrl #(.N_TERO_BITS(5), .N_BITS(2), .WINDOW_CYCLES(4), .CNT_BITS(16)) dut_a (
        .clk  (clk),
        .reset(reset_r),
        .bus  (bus_a)
    );

    tero_scan_ctrl #(.N_TERO_BITS(5), .N_BITS(2), .WINDOW_CYCLES(1), .CNT_BITS(16)) dut_b (
        .clk  (clk),
        .reset(reset_r),
        .bus  (bus_b)
    );

    logic [4:0] m_sel;
    logic       m_en, m_clr, m_busy, m_done;
    logic [1:0] m_resp, m_tie;

    assign m_sel  = use_b ? bus_b.tero_sel : bus_a.tero_sel;
    assign m_en   = use_b ? bus_b.tero_en  : bus_a.tero_en;
    assign m_clr  = use_b ? bus_b.cnt_clr  : bus_a.cnt_clr;
    assign m_busy = use_b ? bus_b.busy     : bus_a.busy;
    assign m_done = use_b ? bus_b.done     : bus_a.done;
    assign m_resp = use_b ? bus_b.response : bus_a.response;
    assign m_tie  = use_b ? bus_b.tie_cnt  : bus_a.tie_cnt;

    int         done_at;
    int         meas_cnt;
    int         sel_unstable;
    int         en_per [8];
    logic [4:0] sel_log [8];
    logic [4:0] cur_sel;

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Loads the four counts of a scan starting at base, wrapping the index like the DUT.
    task automatic apply_stimulus(input logic [15:0] c0, input logic [15:0] c1,
                                  input logic [15:0] c2, input logic [15:0] c3,
                                  input logic [4:0] base);
        logic [4:0] idx;
        for (int i = 0; i < 32; i++) cnt_tab[i] = 16'd0;
        idx = base;
        cnt_tab[idx] = c0; idx = idx + 5'd1;
        cnt_tab[idx] = c1; idx = idx + 5'd1;
        cnt_tab[idx] = c2; idx = idx + 5'd1;
        cnt_tab[idx] = c3;
    endtask

    // Starts a scan and records per-measurement activity until done or the cycle budget ends.
    // Returns sitting at the negedge of the done cycle.
    task automatic run_scan(input logic [4:0] base, input bit pulse_in_run, input int max_cycles);
        bit pulsed;
        pulsed       = 1'b0;
        meas_cnt     = 0;
        done_at      = -1;
        sel_unstable = 0;
        cur_sel      = 5'd0;
        for (int i = 0; i < 8; i++) begin
            en_per[i]  = 0;
            sel_log[i] = 5'd0;
        end
        @(negedge clk);
        start_r = 1'b1;
        base_r  = base;
        for (int c = 1; c <= max_cycles; c++) begin
            @(negedge clk);
            start_r = 1'b0;
            if (m_clr && meas_cnt < 8) begin
                sel_log[meas_cnt] = m_sel;
                cur_sel           = m_sel;
                meas_cnt++;
            end
            if (m_en && meas_cnt > 0 && meas_cnt <= 8) en_per[meas_cnt-1]++;
            if (m_busy && meas_cnt > 0 && m_sel != cur_sel) sel_unstable++;
            if (pulse_in_run && !pulsed && m_en) begin
                start_r = 1'b1;
                pulsed  = 1'b1;
            end
            if (m_done) begin
                done_at = c;
                break;
            end
        end
    endtask

    task automatic check_scan(input string tag, input logic [1:0] exp_resp, input logic [1:0] exp_tie,
                              input int exp_done, input int exp_en, input logic [4:0] base);
        logic [4:0] exp_sel;
        check_output({tag, "_done_lat"}, 32'(done_at), 32'(exp_done));
        check_output({tag, "_resp"}, 32'(m_resp), 32'(exp_resp));
        check_output({tag, "_tie"}, 32'(m_tie), 32'(exp_tie));
        check_output({tag, "_busy_in_done"}, 32'(m_busy), 32'd1);
        check_output({tag, "_meas_cnt"}, 32'(meas_cnt), 32'd4);
        check_output({tag, "_sel_stable"}, 32'(sel_unstable), 32'd0);
        for (int i = 0; i < 4; i++) begin
            exp_sel = base + 5'(i);
            check_output($sformatf("%s_sel%0d", tag, i), 32'(sel_log[i]), 32'(exp_sel));
            check_output($sformatf("%s_en%0d", tag, i), 32'(en_per[i]), 32'(exp_en));
        end
        @(negedge clk);
        check_output({tag, "_done_pulse"}, 32'(m_done), 32'd0);
        check_output({tag, "_busy_after"}, 32'(m_busy), 32'd0);
        check_output({tag, "_resp_hold"}, 32'(m_resp), 32'(exp_resp));
    endtask

    initial begin
        int extra_done;
        int extra_busy;

        reset_r = 1'b1;
        start_r = 1'b0;
        use_b   = 1'b0;
        base_r  = 5'd0;
        for (int i = 0; i < 32; i++) cnt_tab[i] = 16'd0;

        repeat (3) @(negedge clk);
        check_output("rst_en",   32'(m_en),   32'd0);
        check_output("rst_clr",  32'(m_clr),  32'd0);
        check_output("rst_busy", 32'(m_busy), 32'd0);
        check_output("rst_done", 32'(m_done), 32'd0);
        check_output("rst_sel",  32'(m_sel),  32'd0);
        check_output("rst_resp", 32'(m_resp), 32'd0);
        check_output("rst_tie",  32'(m_tie),  32'd0);
        use_b = 1'b1;
        #1;
        check_output("rst_b_en",   32'(m_en),   32'd0);
        check_output("rst_b_busy", 32'(m_busy), 32'd0);
        use_b = 1'b0;
        @(negedge clk);
        reset_r = 1'b0;

        apply_stimulus(16'd100, 16'd50, 16'd100, 16'd50, 5'd0);
        run_scan(5'd0, 1'b0, 60);
        check_scan("order", 2'b11, 2'd0, 33, 4, 5'd0);
        repeat (5) @(negedge clk);
        check_output("order_resp_later", 32'(m_resp), 32'd3);
        check_output("order_tie_later",  32'(m_tie),  32'd0);

        apply_stimulus(16'd10, 16'd200, 16'd65535, 16'd0, 5'd0);
        run_scan(5'd0, 1'b0, 60);
        check_scan("unsigned", 2'b10, 2'd0, 33, 4, 5'd0);

        apply_stimulus(16'd77, 16'd77, 16'd77, 16'd77, 5'd0);
        run_scan(5'd0, 1'b0, 60);
        check_scan("ties", 2'b00, 2'd2, 33, 4, 5'd0);

        apply_stimulus(16'd5, 16'd9, 16'd8, 16'd3, 5'd31);
        run_scan(5'd31, 1'b0, 60);
        check_scan("wrap", 2'b10, 2'd0, 33, 4, 5'd31);

        apply_stimulus(16'd100, 16'd50, 16'd100, 16'd50, 5'd0);
        run_scan(5'd0, 1'b1, 60);
        start_r = 1'b1;
        check_scan("busy_start", 2'b11, 2'd0, 33, 4, 5'd0);
        start_r = 1'b0;
        extra_done = 0;
        extra_busy = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (m_done) extra_done++;
            if (m_busy) extra_busy++;
        end
        check_output("busy_start_extra_done", 32'(extra_done), 32'd0);
        check_output("busy_start_extra_busy", 32'(extra_busy), 32'd0);
        run_scan(5'd0, 1'b0, 60);
        check_scan("after_ignored", 2'b11, 2'd0, 33, 4, 5'd0);

        apply_stimulus(16'd100, 16'd50, 16'd100, 16'd50, 5'd0);
        @(negedge clk);
        start_r = 1'b1;
        base_r  = 5'd0;
        @(negedge clk);
        start_r = 1'b0;
        repeat (18) @(negedge clk);
        check_output("midrst_pre_en",   32'(m_en),   32'd1);
        check_output("midrst_pre_sel",  32'(m_sel),  32'd2);
        check_output("midrst_pre_resp", 32'(m_resp), 32'd1);
        reset_r = 1'b1;
        @(negedge clk);
        check_output("midrst_en",   32'(m_en),   32'd0);
        check_output("midrst_busy", 32'(m_busy), 32'd0);
        check_output("midrst_resp", 32'(m_resp), 32'd0);
        check_output("midrst_tie",  32'(m_tie),  32'd0);
        check_output("midrst_sel",  32'(m_sel),  32'd0);
        reset_r = 1'b0;
        run_scan(5'd0, 1'b0, 60);
        check_scan("post_rst", 2'b11, 2'd0, 33, 4, 5'd0);

        use_b = 1'b1;
        apply_stimulus(16'd100, 16'd50, 16'd100, 16'd50, 5'd0);
        run_scan(5'd0, 1'b0, 60);
        check_scan("win1", 2'b11, 2'd0, 21, 1, 5'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/tero_scan_ctrl.md
TERO_SCAN_CTRL -- requirements
Module: tero_scan_ctrl

Interface
REQ-001 Parameter N_TERO_BITS, default 5, SHALL set the TERO index width.
REQ-002 Parameter N_BITS, default 16, SHALL set the response width, one bit per TERO pair.
REQ-003 Parameter WINDOW_CYCLES, default 1024, SHALL set the excitation window length in clk cycles (min 1).
REQ-004 Parameter CNT_BITS, default 16, SHALL set the oscillation count width.
REQ-005 clk  in  1  rising-edge system clock.
REQ-006 reset  in  1  reset, synchronous, active-high.
REQ-007 start  in  1  request a full scan; sampled only in IDLE.
REQ-008 base_idx  in  N_TERO_BITS  first TERO index of the scan; sampled with start.
REQ-009 cnt_val  in  CNT_BITS  oscillation count from the external frequency counter.
REQ-010 tero_sel  out  N_TERO_BITS  TERO index currently selected.
REQ-011 tero_en  out  1  excites the selected TERO.
REQ-012 cnt_clr  out  1  clears the external counter.
REQ-013 busy  out  1  high from the cycle after start acceptance until DONE is exited.
REQ-014 done  out  1  one-cycle completion pulse.
REQ-015 response  out  N_BITS  PUF response; bit k belongs to pair k.
REQ-016 tie_cnt  out  $clog2(N_BITS+1)  number of pairs with equal counts.

Function
REQ-017 FSM states SHALL be IDLE, CLR, RUN, SETTLE, CAPTURE and DONE.
REQ-018 In IDLE, start=1 SHALL latch base_idx, zero the pair index k and phase, clear response and tie_cnt, and go to CLR.
REQ-019 CLR SHALL last 1 cycle with cnt_clr=1 and tero_en=0.
REQ-020 RUN SHALL last exactly WINDOW_CYCLES cycles with tero_en=1; tero_en SHALL be 0 in every other state.
REQ-021 SETTLE SHALL last 2 cycles with tero_en=0, to absorb counter synchroniser latency.
REQ-022 CAPTURE SHALL last 1 cycle and sample cnt_val:
  - phase A: store cnt_val as count_a.
  - phase B: set response[k] = (count_a > cnt_val).
REQ-023 Tie handling: when count_a == cnt_val, response[k] SHALL be 0 and tie_cnt SHALL increment.
REQ-024 Comparison SHALL be unsigned at CNT_BITS width.
REQ-025 tero_sel SHALL equal base_idx + 2k (phase A) or base_idx + 2k + 1 (phase B), modulo 2^N_TERO_BITS (wrap-around).
REQ-026 tero_sel SHALL be stable from CLR through CAPTURE of each measurement.
REQ-027 After CAPTURE, sequencing SHALL continue as follows:
  - phase A: go to CLR in phase B.
  - phase B, k < N_BITS-1: go to CLR with k+1, phase A.
  - otherwise: go to DONE.
REQ-028 DONE SHALL last 1 cycle with done=1, then return to IDLE.
REQ-029 Each TERO measurement SHALL take WINDOW_CYCLES+4 cycles.
REQ-030 With start accepted at edge t, done SHALL be high in cycle t+1+2*N_BITS*(WINDOW_CYCLES+4).
REQ-031 start outside IDLE, including in DONE, SHALL be ignored.
REQ-032 response and tie_cnt SHALL hold their values after DONE until the next accepted start.

Reset
REQ-033 reset SHALL take priority over all inputs.
REQ-034 On reset, the FSM SHALL go to IDLE and the outputs SHALL be:
  - tero_en, cnt_clr, busy, done = 0.
  - tero_sel, response, tie_cnt = 0.
REQ-035 Reset asserted mid-scan (any state) SHALL abort the scan, and tero_en SHALL be 0 from the following edge.

Structure
REQ-036 Package tero_puf_pkg SHALL hold:
  - the FSM state enum;
  - constant SETTLE_CYCLES = 2;
  - the measurement phase type (A/B).
REQ-037 Sub-module tero_window_timer SHALL implement the loadable RUN/SETTLE down-counter with an expire flag.

Verification
All scenarios use N_BITS=2, WINDOW_CYCLES=4 and N_TERO_BITS=5 unless stated.
REQ-038 Pair order: start, base_idx=0, cnt_val=100 on TERO 0/2 and 50 on TERO 1/3 -> response=2'b11, tie_cnt=0, done high exactly 33 cycles after acceptance.
REQ-039 Ties: all counts 77 -> response=2'b00, tie_cnt=2.
REQ-040 Index wrap: base_idx=31 -> tero_sel sequence 31, 0, 1, 2.
REQ-041 Start while busy: start pulsed in RUN and in DONE -> ignored; exactly one done pulse; next start accepted only in IDLE.
REQ-042 Reset in RUN of pair 1 -> next edge gives tero_en=0, busy=0, response=0; a subsequent start completes normally.
REQ-043 Window length: WINDOW_CYCLES=1 -> tero_en high exactly 1 cycle per measurement; done at cycle t+1+2*2*5 = t+21.
